// File: rtl/load_formatter.sv
// Load formatter: turns a byte-addressed core load (LB/LH/LW/LBU/LHU) into one
// or two word reads on the load unit, then extracts and extends the result.
// Misaligned loads are either split across two words or rejected with an error.
module load_formatter #(
   parameter bit MISALIGNED_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rstn_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic [2:0]  req_funct3_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_data_o,
   output logic        resp_err_o,
   output logic        lu_read_o,
   output logic [31:0] lu_addr_o,
   input  logic        lu_valid_i,
   input  logic [31:0] lu_data_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD0,
      S_GAP,
      S_RD1,
      S_RESP,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] word0_q, word0_d;
   logic [31:0] word1_q, word1_d;

   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic        lu_read_q, lu_read_d;
   logic [31:0] lu_addr_q, lu_addr_d;

   logic [63:0] dword;
   logic [31:0] shifted;
   logic [31:0] extended;

   // Only LB, LH, LW, LBU, LHU are legal load encodings.
   function automatic logic is_illegal(input logic [2:0] f3);
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   // Halfwords cross a word only at offset 3; words at any nonzero offset.
   function automatic logic is_misaligned(input logic [1:0] ofs, input logic [2:0] f3);
      return ((f3[1:0] == 2'b01) && (ofs == 2'b11)) ||
             ((f3[1:0] == 2'b10) && (ofs != 2'b00));
   endfunction

   // Next state and latched request/data words.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      funct3_d = funct3_q;
      word0_d  = word0_q;
      word1_d  = word1_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               addr_d   = req_addr_i;
               funct3_d = req_funct3_i;
               word0_d  = '0;
               word1_d  = '0;
               if (is_illegal(req_funct3_i) ||
                   (!MISALIGNED_EN && is_misaligned(req_addr_i[1:0], req_funct3_i)))
                  state_d = S_ERR;
               else
                  state_d = S_RD0;
            end
         end
         S_RD0: begin
            if (lu_valid_i) begin
               word0_d = lu_data_i;
               state_d = is_misaligned(addr_q[1:0], funct3_q) ? S_GAP : S_RESP;
            end
         end
         S_GAP: state_d = S_RD1;
         S_RD1: begin
            if (lu_valid_i) begin
               word1_d = lu_data_i;
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Extract the addressed bytes from the two-word window and extend them.
   // The _d words already contain the beat being accepted this cycle, so the
   // result is ready to register on the same edge that enters RESP.
   always_comb begin
      dword   = {word1_d, word0_d};
      shifted = dword[{addr_d[1:0], 3'b000} +: 32];
      case (funct3_d)
         3'b000:  extended = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  extended = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  extended = {24'd0, shifted[7:0]};
         3'b101:  extended = {16'd0, shifted[15:0]};
         default: extended = shifted;
      endcase
   end

   // Registered outputs are decoded from the state being entered.
   always_comb begin
      req_ready_d  = (state_d == S_IDLE);
      lu_read_d    = (state_d == S_RD0) || (state_d == S_RD1);
      resp_valid_d = (state_d == S_RESP) || (state_d == S_ERR);
      resp_err_d   = (state_d == S_ERR);
      lu_addr_d    = '0;
      if (state_d == S_RD0)
         lu_addr_d = {addr_d[31:2], 2'b00};
      else if (state_d == S_RD1)
         lu_addr_d = {addr_d[31:2], 2'b00} + 32'd4;
      resp_data_d = resp_data_q;
      if (state_d == S_RESP)
         resp_data_d = extended;
      else if (state_d == S_ERR)
         resp_data_d = '0;
   end

   // State, latched request and registered outputs; reset aborts any transaction.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         funct3_q     <= '0;
         word0_q      <= '0;
         word1_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= '0;
         lu_read_q    <= 1'b0;
         lu_addr_q    <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         funct3_q     <= funct3_d;
         word0_q      <= word0_d;
         word1_q      <= word1_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_data_q  <= resp_data_d;
         lu_read_q    <= lu_read_d;
         lu_addr_q    <= lu_addr_d;
      end
   end

   assign req_ready_o  = req_ready_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_err_o   = resp_err_q;
   assign resp_data_o  = resp_data_q;
   assign lu_read_o    = lu_read_q;
   assign lu_addr_o    = lu_addr_q;

endmodule

// File: doc/load_formatter.md
LOAD_FORMATTER -- requirements
Module: load_formatter

Interface
REQ-001 Parameter: MISALIGNED_EN, default 1, 1 = split misaligned loads into two word reads, 0 = reject them with an error.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid_i  in  1  core load request valid.
REQ-005 Port: req_ready_o  out  1  formatter able to accept a request.
REQ-006 Port: req_addr_i  in  32  byte address of the load.
REQ-007 Port: req_funct3_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 Port: resp_valid_o  out  1  one-cycle response strobe.
REQ-009 Port: resp_data_o  out  32  extended load result.
REQ-010 Port: resp_err_o  out  1  the response is an error; valid only with resp_valid_o.
REQ-011 Port: lu_read_o  out  1  read request to the downstream load unit; held high until lu_valid_i.
REQ-012 Port: lu_addr_o  out  32  word-aligned address to the load unit; bits [1:0] always 00.
REQ-013 Port: lu_valid_i  in  1  load unit data valid.
REQ-014 Port: lu_data_i  in  32  load unit read data, little-endian.

Function
REQ-015 The block SHALL implement the states IDLE, RD0, GAP, RD1, RESP and ERR.
REQ-016 IDLE: req_ready_o=1; on req_valid_i the block SHALL latch addr/funct3 and leave IDLE next cycle; req_ready_o=0 in all other states, and req_valid_i is ignored there.
REQ-017 Illegal funct3 (011, 110, 111), or a misaligned request with MISALIGNED_EN=0, SHALL go IDLE->ERR with no load-unit access.
REQ-018 Misaligned request definitions: halfword with addr[1:0]=11; word with addr[1:0]!=00; bytes are never misaligned.
REQ-019 RD0: lu_read_o=1 and lu_addr_o={addr[31:2],2'b00}; on lu_valid_i latch word0, then go to GAP if the request is misaligned, otherwise go to RESP.
REQ-020 GAP: lu_read_o=0 for exactly one cycle, so the load unit returns to idle; next state is RD1.
REQ-021 RD1: lu_read_o=1 and lu_addr_o={addr[31:2],2'b00}+4, wrapping modulo 2^32; on lu_valid_i latch word1, then go to RESP.
REQ-022 Outside RD0/RD1: lu_read_o=0 and lu_addr_o=0.
REQ-023 Extraction: shift the 64-bit value {word1,word0} right by 8*addr[1:0], then take bits [7:0], [15:0] or [31:0] according to size; word1 is 0 for non-split loads.
REQ-024 LB/LH SHALL sign-extend to 32 bits, LBU/LHU SHALL zero-extend, and LW SHALL pass the data unchanged.
REQ-025 RESP: resp_valid_o=1 and resp_err_o=0 for exactly one cycle, then go to IDLE.
REQ-026 ERR: resp_valid_o=1, resp_err_o=1 and resp_data_o=0 for exactly one cycle, then go to IDLE.
REQ-027 resp_data_o SHALL be registered and SHALL hold its last value until the next response.
REQ-028 Latency of an aligned load: request accepted at cycle T; lu_read_o high from T+1; resp_valid_o at cycle V+1, where V is the lu_valid_i cycle.
REQ-029 Latency of a split load: GAP at V0+1; RD1 from V0+2; resp_valid_o at V1+1.
REQ-030 Latency of an error: resp_valid_o at T+1.
REQ-031 lu_valid_i outside RD0/RD1 SHALL be ignored.
REQ-032 A new request SHALL NOT be accepted in the same cycle that resp_valid_o is high.

Reset
REQ-033 While rstn_i=0, outputs SHALL be: state=IDLE, req_ready_o=1, resp_valid_o=0, resp_err_o=0, resp_data_o=0, lu_read_o=0, lu_addr_o=0, and latched word0/word1/addr/funct3 cleared.
REQ-034 Reset asserted mid-transaction (any state) SHALL abort it immediately with no response; the first cycle after release is IDLE.

Verification
REQ-035 LW at 0x1000; lu_data_i=0xDEADBEEF after 2 cycles -> one lu_read_o burst at 0x1000, resp_data_o=0xDEADBEEF, resp_err_o=0.
REQ-036 LB and LBU at 0x2003 with word 0x80FF_0000 -> LB gives 0xFFFFFF80, LBU gives 0x00000080.
REQ-037 LW at 0x3002, MISALIGNED_EN=1; words 0x44332211 and 0x88776655 -> reads at 0x3000 and 0x3004 with exactly one low cycle between them; result 0x66554433.
REQ-038 LH at 0xFFFFFFFF; words 0x12xxxxxx and 0xxxxxxx34 -> second read at 0x00000000; result 0x00003412.
REQ-039 funct3=011, and separately LW at 0x5001 with MISALIGNED_EN=0 -> resp_err_o=1 at T+1, lu_read_o never high.
REQ-040 rstn_i low during RD1, then released -> no resp_valid_o, all outputs at reset values, next LW completes normally.
